// File: rtl/uart_rx_param_fifo_pkg.sv
// Shared definitions for the parametrised UART receiver: FSM state
// encoding, status-field offsets above the data bits in a FIFO entry,
// and the parity helper used when the frame carries a parity bit.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5,
        PUSH   = 3'd6
    } rx_state_e;

    // Status bit offsets, added to DATA_W to locate each flag in an entry.
    localparam int FE_O   = 0;
    localparam int PE_O   = 1;
    localparam int OE_O   = 2;
    localparam int BE_O   = 3;
    localparam int BRK_O  = 4;
    localparam int STAT_W = 5;

    // Expected parity bit for up to 9 data bits. Unused upper bits must be
    // zero, which leaves the XOR reduction unaffected.
    function automatic logic calc_parity(input logic [8:0] data, input logic odd);
        logic p;
        p = ^data;
        return odd ? ~p : p;
    endfunction

endpackage

// File: rtl/uart_rx_param_fifo_sync_fifo.sv
// Generic single-clock FIFO with registered read data and registered
// occupancy flags. A pop on an empty FIFO is ignored; a push on a full
// FIFO only lands when a pop happens in the same cycle.
module uart_rx_sync_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [WIDTH-1:0] dout_q;
    logic             full_q;
    logic             empty_q;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify requests against the current flags and form the next occupancy.
    always_comb begin
        pop_ok_s  = pop & ~empty_q;
        push_ok_s = push & (~full_q | pop_ok_s);
        count_d   = count_q;
        if (push_ok_s && !pop_ok_s) begin
            count_d = count_q + CNT_ONE;
        end else if (!push_ok_s && pop_ok_s) begin
            count_d = count_q - CNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Storage array; contents need no reset because pointers gate every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers, read register and occupancy flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
                dout_q   <= mem_q[rd_ptr_q];
            end
            count_q <= count_d;
            full_q  <= (count_d == CNT_FULL);
            empty_q <= (count_d == '0);
        end
    end

    assign dout  = dout_q;
    assign count = count_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/uart_rx_param_fifo.sv
// Parametrised UART receiver with a status-tagged receive FIFO.
// Each character is stored as {BRK, BE, OE, PE, FE, data}.
// Optional build macro UART_RX_SYNC_EN: when defined, rx passes through a
// two-flop synchroniser (reset value 1) ahead of the FSM, shifting every
// detection and sample point by two cycles. When undefined, rx must come
// from a source already synchronous to UART_clk.
module uart_rx_param_fifo
    import uart_rx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int OVS        = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int PAR_EN     = 1
) (
    input  logic                          UART_clk,
    input  logic                          rst_n,
    input  logic                          rx,
    input  logic                          parity_odd,
    input  logic                          stop2,
    input  logic                          rd_en,
    input  logic                          ovr_clr,
    output logic [DATA_W+4:0]             rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overrun
);

    localparam int EW = DATA_W + STAT_W;
    localparam int H  = OVS / 2;
    localparam int TW = $clog2(OVS + 1);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [TW-1:0] TICK_H     = TW'(H);
    localparam logic [TW-1:0] TICK_LAST  = TW'(OVS - 1);
    localparam logic [TW-1:0] TICK_ONE   = TW'(1);
    // The detecting IDLE cycle is tick 0, so the following cycle is tick 1
    // (or tick 0 again when each bit lasts a single cycle).
    localparam logic [TW-1:0] TICK_START = TW'((OVS > 1) ? 1 : 0);
    localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_W - 1);
    localparam logic [BW-1:0] BIT_ONE    = BW'(1);

    logic              rx_s;
    rx_state_e         state_q;
    rx_state_e         state_d;
    logic [TW-1:0]     tick_q;
    logic [TW-1:0]     tick_d;
    logic [BW-1:0]     bit_q;
    logic [BW-1:0]     bit_d;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic              fe_q;
    logic              fe_d;
    logic              pe_q;
    logic              pe_d;
    logic              par_q;
    logic              par_d;
    logic              prev_zero_q;
    logic              prev_zero_d;
    logic              overrun_q;
    logic              overrun_d;
    logic              sample_s;
    logic              push_s;
    logic              zero_s;
    logic [EW-1:0]     entry_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              drop_s;

`ifdef UART_RX_SYNC_EN
    logic rx_meta_q;
    logic rx_sync_q;

    // Two-flop synchroniser for an asynchronous serial input.
    always_ff @(posedge UART_clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    assign rx_s = rx_sync_q;
`else
    assign rx_s = rx;
`endif

    assign sample_s = (tick_q == TICK_H);

    // FSM state register.
    always_ff @(posedge UART_clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; every bit decision is taken at the sample tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    if (H == 0) begin
                        state_d = DATA;
                    end else begin
                        state_d = START;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (sample_s) begin
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (sample_s && (bit_q == BIT_LAST)) begin
                    state_d = (PAR_EN != 0) ? PARITY : STOP1;
                end else begin
                    state_d = DATA;
                end
            end
            PARITY: begin
                if (sample_s) begin
                    state_d = STOP1;
                end else begin
                    state_d = PARITY;
                end
            end
            STOP1: begin
                if (sample_s) begin
                    state_d = stop2 ? STOP2 : PUSH;
                end else begin
                    state_d = STOP1;
                end
            end
            STOP2: begin
                if (sample_s) begin
                    state_d = PUSH;
                end else begin
                    state_d = STOP2;
                end
            end
            PUSH:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs and datapath next values: tick counting, bit capture,
    // status accumulation and the one-cycle push strobe.
    always_comb begin
        tick_d      = (tick_q == TICK_LAST) ? '0 : (tick_q + TICK_ONE);
        bit_d       = bit_q;
        shift_d     = shift_q;
        fe_d        = fe_q;
        pe_d        = pe_q;
        par_d       = par_q;
        prev_zero_d = prev_zero_q;
        push_s      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    tick_d = TICK_START;
                    bit_d  = '0;
                    fe_d   = 1'b0;
                    pe_d   = 1'b0;
                    par_d  = 1'b0;
                end else begin
                    tick_d = '0;
                end
            end
            START: begin
                tick_d = (tick_q == TICK_LAST) ? '0 : (tick_q + TICK_ONE);
            end
            DATA: begin
                if (sample_s) begin
                    shift_d = {rx_s, shift_q[DATA_W-1:1]};
                    bit_d   = bit_q + BIT_ONE;
                end else begin
                    shift_d = shift_q;
                end
            end
            PARITY: begin
                if (sample_s) begin
                    par_d = rx_s;
                    pe_d  = (rx_s != calc_parity(9'(shift_q), parity_odd));
                end else begin
                    par_d = par_q;
                end
            end
            STOP1: begin
                if (sample_s) begin
                    fe_d = ~rx_s;
                end else begin
                    fe_d = fe_q;
                end
            end
            STOP2: begin
                if (sample_s) begin
                    fe_d = fe_q | ~rx_s;
                end else begin
                    fe_d = fe_q;
                end
            end
            PUSH: begin
                push_s      = 1'b1;
                prev_zero_d = zero_s;
            end
            default: begin
                push_s = 1'b0;
            end
        endcase
    end

    // Tagged entry assembled from the captured frame; par_q stays 0 when
    // the frame has no parity bit, so BRK then depends on data and FE only.
    always_comb begin
        zero_s  = (shift_q == '0);
        entry_s = '0;
        entry_s[DATA_W-1:0]     = shift_q;
        entry_s[DATA_W + FE_O]  = fe_q;
        entry_s[DATA_W + PE_O]  = pe_q;
        entry_s[DATA_W + OE_O]  = overrun_q;
        entry_s[DATA_W + BE_O]  = zero_s & prev_zero_q;
        entry_s[DATA_W + BRK_O] = zero_s & fe_q & ~par_q;
    end

    // A frame is lost only when the FIFO is full and no pop frees a slot.
    always_comb begin
        drop_s = push_s & fifo_full_s & ~(rd_en & ~fifo_empty_s);
        if (drop_s) begin
            overrun_d = 1'b1;
        end else if (ovr_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge UART_clk) begin
        if (!rst_n) begin
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            fe_q        <= 1'b0;
            pe_q        <= 1'b0;
            par_q       <= 1'b0;
            prev_zero_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            fe_q        <= fe_d;
            pe_q        <= pe_d;
            par_q       <= par_d;
            prev_zero_q <= prev_zero_d;
            overrun_q   <= overrun_d;
        end
    end

    uart_rx_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (UART_clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (rd_en),
        .din   (entry_s),
        .dout  (rd_data),
        .count (count),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign full    = fifo_full_s;
    assign empty   = fifo_empty_s;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_param_fifo.sv
// Scoreboard bench for uart_rx_param_fifo: frames are serialised on rx, a
// frame-level model computes the tagged entry and FIFO effect, and a
// monitor compares rd_data against the expected queue after every pop.
`timescale 1ns/1ps
module tb_uart_rx_param_fifo;

    localparam int DATA_W     = 8;
    localparam int OVS        = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int PAR_EN     = 1;
    localparam int EW         = DATA_W + 5;
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx = 1'b1;
    logic          parity_odd = 1'b0;
    logic          stop2 = 1'b0;
    logic          rd_en = 1'b0;
    logic          ovr_clr = 1'b0;
    logic [EW-1:0] rd_data;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          overrun;

    always #5 clk = ~clk;

    uart_rx_param_fifo #(
        .DATA_W     (DATA_W),
        .OVS        (OVS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .PAR_EN     (PAR_EN)
    ) dut (
        .UART_clk   (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .parity_odd (parity_odd),
        .stop2      (stop2),
        .rd_en      (rd_en),
        .ovr_clr    (ovr_clr),
        .rd_data    (rd_data),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .overrun    (overrun)
    );

    int            checks = 0;
    int            errors = 0;
    logic [EW-1:0] model_q[$];
    logic [EW-1:0] exp_q[$];
    logic          m_ovr = 1'b0;
    logic          m_prev_zero = 1'b0;
    logic [EW-1:0] m_last = '0;
    logic          mon_pend = 1'b0;
    logic [EW-1:0] mon_exp;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: a pop accepted at an edge is compared at the next falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_pend) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got %0h expected no entry", rd_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("rd_data", 32'(rd_data), 32'(mon_exp));
                end
            end
            mon_pend = rst_n && rd_en && !empty;
        end
    end

    function automatic logic good_par(input logic [DATA_W-1:0] d);
        return parity_odd ? ~^d : ^d;
    endfunction

    task automatic bit_out(input logic b);
        rx = b;
        repeat (OVS) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Frame-level reference: status flags from the frame rules, then the
    // FIFO/overrun effect of the push.
    task automatic model_frame(input logic [DATA_W-1:0] d, input logic pb,
                               input logic s1, input logic s2);
        logic fe, pe, z, be, brk;
        logic [EW-1:0] ent;
        fe  = !s1 || (stop2 && !s2);
        pe  = (PAR_EN != 0) && (pb != good_par(d));
        z   = (d == '0);
        be  = z && m_prev_zero;
        brk = z && fe && ((PAR_EN == 0) || !pb);
        m_prev_zero = z;
        ent = {brk, be, m_ovr, pe, fe, d};
        if (model_q.size() == FIFO_DEPTH) m_ovr = 1'b1;
        else model_q.push_back(ent);
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] d, input logic pb,
                              input logic s1, input logic s2);
        bit_out(1'b0);
        for (int i = 0; i < DATA_W; i++) bit_out(d[i]);
        if (PAR_EN != 0) bit_out(pb);
        bit_out(s1);
        if (stop2) bit_out(s2);
        bit_out(1'b1);
        bit_out(1'b1);
        model_frame(d, pb, s1, s2);
    endtask

    task automatic send_good(input logic [DATA_W-1:0] d);
        send_frame(d, good_par(d), 1'b1, 1'b1);
    endtask

    task automatic do_pop();
        logic had;
        had = (model_q.size() > 0);
        rd_en = 1'b1;
        if (had) begin
            m_last = model_q.pop_front();
            exp_q.push_back(m_last);
        end
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        if (!had) check("rd_hold", 32'(rd_data), 32'(m_last));
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_count"}, 32'(count), 32'(model_q.size()));
        check({tag, "_empty"}, 32'(empty), 32'(model_q.size() == 0));
        check({tag, "_full"}, 32'(full), 32'(model_q.size() == FIFO_DEPTH));
        check({tag, "_overrun"}, 32'(overrun), 32'(m_ovr));
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        rx    = 1'b1;
        rd_en = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        model_q.delete();
        exp_q.delete();
        m_ovr       = 1'b0;
        m_prev_zero = 1'b0;
        m_last      = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        ovr_clr = 1'b1;
        @(posedge clk);
        #1;
        ovr_clr = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic drain();
        while (model_q.size() > 0) do_pop();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DATA_W-1:0] d;
        logic pb, s1, s2;

        reset_dut();
        check("rst_rd_data", 32'(rd_data), 32'h0);
        check_status("rst");

        // Clean odd-parity frame, then pop it back out.
        parity_odd = 1'b1;
        stop2      = 1'b0;
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
        check_status("a5");
        do_pop();
        check_status("a5_pop");

        // Framing error, then parity error.
        send_frame(8'h5A, good_par(8'h5A), 1'b0, 1'b1);
        send_frame(8'h3C, ^(8'h3C), 1'b1, 1'b1);
        check_status("fe_pe");
        drain();

        // Blank pair, then a break frame.
        send_good(8'h00);
        send_good(8'h00);
        send_frame(8'h00, 1'b0, 1'b0, 1'b1);
        check_status("be_brk");
        drain();

        // Short low glitch is a false start.
        rx = 1'b0;
        @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (3 * OVS) begin
            @(posedge clk);
            #1;
        end
        check_status("glitch");
        send_good(8'h81);
        check_status("after_glitch");
        drain();

        // Overflow: one more frame than the FIFO holds.
        for (int i = 0; i < FIFO_DEPTH + 1; i++) send_good(8'(8'h20 + i));
        check_status("ovf");
        do_pop();
        send_good(8'h11);
        check_status("ovf_refill");
        pulse_clr();
        check_status("ovr_clr");
        drain();

        // Two stop bits, second one bad, then a good one.
        stop2 = 1'b1;
        send_frame(8'h7F, good_par(8'h7F), 1'b1, 1'b0);
        send_good(8'h42);
        check_status("stop2");
        drain();
        stop2 = 1'b0;

        // Pop on empty leaves rd_data unchanged.
        do_pop();
        check_status("empty_pop");

        // Randomised frames with sporadic errors, pops and clears.
        for (int n = 0; n < 30; n++) begin
            parity_odd = 1'($urandom_range(0, 1));
            stop2      = 1'($urandom_range(0, 1));
            d  = ($urandom_range(0, 3) == 0) ? '0 : DATA_W'($urandom_range(0, 255));
            pb = good_par(d) ^ ($urandom_range(0, 3) == 0);
            s1 = ($urandom_range(0, 4) != 0);
            s2 = ($urandom_range(0, 4) != 0);
            send_frame(d, pb, s1, s2);
            check_status("rnd");
            if ($urandom_range(0, 2) == 0) do_pop();
            if ($urandom_range(0, 6) == 0) pulse_clr();
        end
        drain();
        check("rnd_drained", 32'(exp_q.size()), 32'd0);
        stop2 = 1'b0;

        // Reset in the middle of the data bits aborts the frame.
        send_good(8'h33);
        bit_out(1'b0);
        bit_out(1'b1);
        bit_out(1'b0);
        bit_out(1'b1);
        reset_dut();
        repeat (2 * OVS) begin
            @(posedge clk);
            #1;
        end
        check("mid_rst_rd_data", 32'(rd_data), 32'h0);
        check_status("mid_rst");
        parity_odd = 1'b0;
        send_good(8'h66);
        check_status("post_rst");
        drain();

        check("final_exp_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
